// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop are reused across WIDTH RUN cycles.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state, state_next;
    logic [WIDTH-1:0] a_sr, a_sr_next;
    logic [WIDTH-1:0] b_sr, b_sr_next;
    logic [WIDTH-1:0] res_sr, res_sr_next;
    logic             br, br_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             a_msb, a_msb_next;
    logic             b_msb, b_msb_next;
    logic [WIDTH-1:0] diff_next;
    logic             bout_next, ovf_next, busy_next, done_next, start_ready_next;

    // Full-subtractor cell and the result register with the new bit shifted into its MSB
    logic             ai, bi, d, br_cell;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        ai        = a_sr[0];
        bi        = b_sr[0];
        d         = ai ^ bi ^ br;
        br_cell   = (~ai & bi) | (~(ai ^ bi) & br);
        res_shift = (res_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));
    end

    // Next-state and next-register logic; every register holds unless its state updates it
    always_comb begin
        state_next       = state;
        a_sr_next        = a_sr;
        b_sr_next        = b_sr;
        res_sr_next      = res_sr;
        br_next          = br;
        cnt_next         = cnt;
        a_msb_next       = a_msb;
        b_msb_next       = b_msb;
        diff_next        = diff;
        bout_next        = bout;
        ovf_next         = ovf;
        busy_next        = busy;
        done_next        = 1'b0;
        start_ready_next = start_ready;

        case (state)
            ST_IDLE: begin
                if (start_valid) begin
                    a_sr_next        = a;
                    b_sr_next        = b;
                    br_next          = bin;
                    res_sr_next      = '0;
                    cnt_next         = '0;
                    a_msb_next       = a[WIDTH-1];
                    b_msb_next       = b[WIDTH-1];
                    busy_next        = 1'b1;
                    start_ready_next = 1'b0;
                    state_next       = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sr_next   = a_sr >> 1;
                b_sr_next   = b_sr >> 1;
                res_sr_next = res_shift;
                br_next     = br_cell;
                cnt_next    = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    diff_next  = res_shift;
                    bout_next  = br_cell;
                    ovf_next   = (a_msb ^ b_msb) & (res_shift[WIDTH-1] ^ a_msb);
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_next        = 1'b0;
                start_ready_next = 1'b1;
                state_next       = ST_IDLE;
            end
            default: begin
                busy_next        = 1'b0;
                start_ready_next = 1'b1;
                state_next       = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            res_sr      <= '0;
            br          <= 1'b0;
            cnt         <= '0;
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            diff        <= '0;
            bout        <= 1'b0;
            ovf         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            state       <= state_next;
            a_sr        <= a_sr_next;
            b_sr        <= b_sr_next;
            res_sr      <= res_sr_next;
            br          <= br_next;
            cnt         <= cnt_next;
            a_msb       <= a_msb_next;
            b_msb       <= b_msb_next;
            diff        <= diff_next;
            bout        <= bout_next;
            ovf         <= ovf_next;
            busy        <= busy_next;
            done        <= done_next;
            start_ready <= start_ready_next;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH = 8, 4 and 1.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst_n;

    logic       v8, r8, bin8, bout8, ovf8, busy8, done8;
    logic [7:0] a8, b8, diff8;
    logic       v4, r4, bin4, bout4, ovf4, busy4, done4;
    logic [3:0] a4, b4, diff4;
    logic       v1, r1, bin1, bout1, ovf1, busy1, done1;
    logic [0:0] a1, b1, diff1;

    int n_tests, n_fail, cyc;
    int acc8, acc4, acc1;
    int acc_cnt8, acc_cnt4, acc_cnt1;
    int done_cnt8, done_cnt4, done_cnt1;
    bit dp8, dp4, dp1;
    logic [31:0] hold8, hold4, hold1;
    exp_t q8[$];
    exp_t q4[$];
    exp_t q1[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(v8), .start_ready(r8),
        .a(a8), .b(b8), .bin(bin8), .diff(diff8), .bout(bout8), .ovf(ovf8),
        .busy(busy8), .done(done8)
    );
    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid(v4), .start_ready(r4),
        .a(a4), .b(b4), .bin(bin4), .diff(diff4), .bout(bout4), .ovf(ovf4),
        .busy(busy4), .done(done4)
    );
    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_valid(v1), .start_ready(r1),
        .a(a1), .b(b1), .bin(bin1), .diff(diff1), .bout(bout1), .ovf(ovf1),
        .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endfunction

    // Reference: plain integer subtraction; borrow = negative result, overflow from operand/result signs
    function automatic exp_t model(input int w, input int a, input int b, input int bi);
        int m, r, u;
        exp_t e;
        m = 1 << w;
        r = a - b - bi;
        u = (r + m) % m;
        e.diff = 8'(u);
        e.bout = (r < 0);
        e.ovf  = ((a >= m / 2) != (b >= m / 2)) && ((u >= m / 2) != (a >= m / 2));
        return e;
    endfunction

    task automatic go8(input int a, input int b, input int bi, input bit push);
        int n;
        @(negedge clk);
        a8 = 8'(a); b8 = 8'(b); bin8 = 1'(bi); v8 = 1'b1;
        n = 0;
        while (!r8 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("go8_timeout", 32'd0, 32'd1);
        if (push) begin q8.push_back(model(8, a, b, bi)); acc_cnt8++; end
        @(posedge clk); #1;
        acc8 = cyc;
        v8 = 1'b0;
    endtask

    task automatic go4(input int a, input int b, input int bi);
        int n;
        @(negedge clk);
        a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bi); v4 = 1'b1;
        n = 0;
        while (!r4 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("go4_timeout", 32'd0, 32'd1);
        q4.push_back(model(4, a, b, bi));
        acc_cnt4++;
        @(posedge clk); #1;
        acc4 = cyc;
        v4 = 1'b0;
    endtask

    task automatic go1(input int a, input int b, input int bi);
        int n;
        @(negedge clk);
        a1 = 1'(a); b1 = 1'(b); bin1 = 1'(bi); v1 = 1'b1;
        n = 0;
        while (!r1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("go1_timeout", 32'd0, 32'd1);
        q1.push_back(model(1, a, b, bi));
        acc_cnt1++;
        @(posedge clk); #1;
        acc1 = cyc;
        v1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q8.size() != 0 || q4.size() != 0 || q1.size() != 0) && n < 400) begin
            @(negedge clk); n++;
        end
        if (n >= 400) chk("drain_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor WIDTH=8
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            done_cnt8++;
            chk("pulse8", 32'(dp8), 32'd0);
            if (q8.size() == 0) chk("spurious_done8", 32'd1, 32'd0);
            else begin
                e = q8.pop_front();
                chk("res8", 32'({diff8, bout8, ovf8}), 32'({e.diff, e.bout, e.ovf}));
                chk("lat8", 32'(cyc - acc8), 32'd8);
                hold8 = 32'({e.diff, e.bout, e.ovf});
            end
        end else if (busy8) begin
            chk("hold8", 32'({diff8, bout8, ovf8}), hold8);
            chk("rdy_busy8", 32'(r8), 32'd0);
        end
        if (dp8) chk("ret8", 32'({r8, busy8}), 32'd2);
        dp8 = done8;
    end

    // Monitor WIDTH=4
    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            done_cnt4++;
            chk("pulse4", 32'(dp4), 32'd0);
            if (q4.size() == 0) chk("spurious_done4", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                chk("res4", 32'({diff4, bout4, ovf4}), 32'({e.diff[3:0], e.bout, e.ovf}));
                chk("lat4", 32'(cyc - acc4), 32'd4);
                hold4 = 32'({e.diff[3:0], e.bout, e.ovf});
            end
        end else if (busy4) begin
            chk("hold4", 32'({diff4, bout4, ovf4}), hold4);
            chk("rdy_busy4", 32'(r4), 32'd0);
        end
        if (dp4) chk("ret4", 32'({r4, busy4}), 32'd2);
        dp4 = done4;
    end

    // Monitor WIDTH=1
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            done_cnt1++;
            chk("pulse1", 32'(dp1), 32'd0);
            if (q1.size() == 0) chk("spurious_done1", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("res1", 32'({diff1, bout1, ovf1}), 32'({e.diff[0], e.bout, e.ovf}));
                chk("lat1", 32'(cyc - acc1), 32'd1);
                hold1 = 32'({e.diff[0], e.bout, e.ovf});
            end
        end else if (busy1) begin
            chk("hold1", 32'({diff1, bout1, ovf1}), hold1);
        end
        if (dp1) chk("ret1", 32'({r1, busy1}), 32'd2);
        dp1 = done1;
    end

    initial begin
        int n;
        n_tests = 0; n_fail = 0; cyc = 0;
        acc8 = 0; acc4 = 0; acc1 = 0;
        acc_cnt8 = 0; acc_cnt4 = 0; acc_cnt1 = 0;
        done_cnt8 = 0; done_cnt4 = 0; done_cnt1 = 0;
        hold8 = 0; hold4 = 0; hold1 = 0;
        rst_n = 1'b0;
        v8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        v4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        v1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst8", 32'({diff8, bout8, ovf8, done8, busy8, r8}), 32'd1);
        chk("rst4", 32'({diff4, bout4, ovf4, done4, busy4, r4}), 32'd1);
        chk("rst1", 32'({diff1, bout1, ovf1, done1, busy1, r1}), 32'd1);
        rst_n = 1'b1;

        // Directed vectors, then random 8-bit operands
        go8(8'h05, 8'h03, 0, 1'b1);
        go8(8'h03, 8'h05, 0, 1'b1);
        go8(8'h00, 8'h00, 1, 1'b1);
        go8(8'h80, 8'h01, 0, 1'b1);
        go8(8'h80, 8'h00, 1, 1'b1);
        go8(8'h7F, 8'hFF, 0, 1'b1);
        repeat (20) go8(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)), 1'b1);
        drain();

        // start_valid held high with operands changing during RUN and DONE
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; bin8 = 1'b1; v8 = 1'b1;
        q8.push_back(model(8, 8'h5A, 8'h33, 1));
        acc_cnt8++;
        @(posedge clk); #1;
        acc8 = cyc;
        n = 0;
        do begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            n++;
        end while (!r8 && n < 40);
        if (n >= 40) chk("hold_valid_timeout", 32'd0, 32'd1);
        q8.push_back(model(8, int'(a8), int'(b8), int'(bin8)));
        acc_cnt8++;
        @(posedge clk); #1;
        acc8 = cyc;
        v8 = 1'b0;
        drain();

        // Reset during the 4th RUN cycle aborts the operation
        go8(8'h37, 8'h21, 0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        hold8 = 0; hold4 = 0; hold1 = 0;
        chk("abort8", 32'({diff8, bout8, ovf8, done8, busy8, r8}), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        go8(8'h10, 8'h01, 0, 1'b1);
        drain();

        // WIDTH=4 exhaustive, back-to-back
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++)
                    go4(a, b, bi);
        drain();

        // WIDTH=1 smoke plus every combination
        go1(0, 1, 0);
        for (int k = 0; k < 8; k++) go1(k & 1, (k >> 1) & 1, (k >> 2) & 1);
        drain();

        chk("done_count8", 32'(done_cnt8), 32'(acc_cnt8));
        chk("done_count4", 32'(done_cnt4), 32'(acc_cnt4));
        chk("done_count1", 32'(done_cnt1), 32'(acc_cnt1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
